// File: rtl/noc_axi4_bridge_req_issue_if.sv
// Bus bundle for the NoC-AXI4 bridge request issue stage: the request input
// from the deserializer, the AXI4 AR/AW/W channels and the header handoff to
// the response path. "master" is the issue block's view, "slave" the view of
// everything around it.
`timescale 1ns/1ps
`ifndef NOC_AXI4_BRIDGE_DEFS
`define NOC_AXI4_BRIDGE_DEFS
`define MSG_HEADER_WIDTH 192
`define AXI4_DATA_WIDTH 512
`define AXI4_ADDR_WIDTH 64
`define AXI4_ID_WIDTH 16
`define AXI4_STRB_WIDTH 64
`define MSG_TYPE 29:22
`define MSG_ADDR 111:64
`define MSG_DATA_SIZE 132:130
`define MSG_TYPE_LOAD_MEM 8'd19
`define MSG_TYPE_STORE_MEM 8'd20
`define MSG_TYPE_NC_LOAD_REQ 8'd14
`define MSG_TYPE_NC_STORE_REQ 8'd15
`endif

interface noc_axi4_bridge_req_issue_if;
   logic [`MSG_HEADER_WIDTH-1:0] req_header;
   logic [`AXI4_DATA_WIDTH-1:0]  req_data;
   logic                         req_val;
   logic                         req_rdy;

   logic [`AXI4_ADDR_WIDTH-1:0]  m_axi_araddr;
   logic [`AXI4_ID_WIDTH-1:0]    m_axi_arid;
   logic [7:0]                   m_axi_arlen;
   logic [2:0]                   m_axi_arsize;
   logic [1:0]                   m_axi_arburst;
   logic                         m_axi_arvalid;
   logic                         m_axi_arready;

   logic [`AXI4_ADDR_WIDTH-1:0]  m_axi_awaddr;
   logic [`AXI4_ID_WIDTH-1:0]    m_axi_awid;
   logic [7:0]                   m_axi_awlen;
   logic [2:0]                   m_axi_awsize;
   logic [1:0]                   m_axi_awburst;
   logic                         m_axi_awvalid;
   logic                         m_axi_awready;

   logic [`AXI4_DATA_WIDTH-1:0]  m_axi_wdata;
   logic [`AXI4_STRB_WIDTH-1:0]  m_axi_wstrb;
   logic                         m_axi_wlast;
   logic                         m_axi_wvalid;
   logic                         m_axi_wready;

   logic [`MSG_HEADER_WIDTH-1:0] hdr_out;
   logic                         hdr_is_wr;
   logic                         hdr_val;
   logic                         hdr_rdy;

   logic                         err_unsupported;

   modport master (
      input  req_header, req_data, req_val,
      output req_rdy,
      output m_axi_araddr, m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
      input  m_axi_arready,
      output m_axi_awaddr, m_axi_awid, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
      input  m_axi_awready,
      output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
      input  m_axi_wready,
      output hdr_out, hdr_is_wr, hdr_val,
      input  hdr_rdy,
      output err_unsupported
   );

   modport slave (
      output req_header, req_data, req_val,
      input  req_rdy,
      input  m_axi_araddr, m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
      output m_axi_arready,
      input  m_axi_awaddr, m_axi_awid, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
      output m_axi_awready,
      input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
      output m_axi_wready,
      input  hdr_out, hdr_is_wr, hdr_val,
      output hdr_rdy,
      input  err_unsupported
   );
endinterface

// File: rtl/noc_axi4_bridge_req_issue.sv
// Request issue stage of the NoC-AXI4 bridge. Takes one assembled NoC request
// at a time, turns it into a single-beat AXI4 read (AR) or write (AW+W) and
// hands the original header to the response path in parallel.
`timescale 1ns/1ps
`ifndef NOC_AXI4_BRIDGE_DEFS
`define NOC_AXI4_BRIDGE_DEFS
`define MSG_HEADER_WIDTH 192
`define AXI4_DATA_WIDTH 512
`define AXI4_ADDR_WIDTH 64
`define AXI4_ID_WIDTH 16
`define AXI4_STRB_WIDTH 64
`define MSG_TYPE 29:22
`define MSG_ADDR 111:64
`define MSG_DATA_SIZE 132:130
`define MSG_TYPE_LOAD_MEM 8'd19
`define MSG_TYPE_STORE_MEM 8'd20
`define MSG_TYPE_NC_LOAD_REQ 8'd14
`define MSG_TYPE_NC_STORE_REQ 8'd15
`endif

module noc_axi4_bridge_req_issue #(
   parameter logic [`AXI4_ID_WIDTH-1:0] AXI_ID         = '0,
   parameter bit                        ADDR_MASK_LINE = 1'b1
) (
   input logic                          clk,
   input logic                          rst,
   noc_axi4_bridge_req_issue_if.master  bus
);

   localparam int NOC_ADDR_WIDTH = 48;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE_RD = 2'd1,
      ISSUE_WR = 2'd2
   } state_t;

   state_t state;

   logic [`MSG_HEADER_WIDTH-1:0] hdr_q;
   logic [`AXI4_ADDR_WIDTH-1:0]  addr_q;
   logic [`AXI4_DATA_WIDTH-1:0]  wdata_q;
   logic [`AXI4_STRB_WIDTH-1:0]  wstrb_q;
   logic                         is_wr_q;

   logic arvalid_q, awvalid_q, wvalid_q, hdr_val_q, err_q;
   logic ar_done, aw_done, w_done, hdr_done;

   logic [7:0]                  req_type;
   logic [NOC_ADDR_WIDTH-1:0]   noc_addr;
   logic [5:0]                  off;
   logic [2:0]                  size_log;
   logic [6:0]                  nbytes;
   logic [63:0]                 span;
   logic                        is_rd_type, is_wr_type, is_nc_store;
   logic                        accept;
   logic [`AXI4_ADDR_WIDTH-1:0] addr_next;
   logic [`AXI4_STRB_WIDTH-1:0] strb_next;
   logic [`AXI4_DATA_WIDTH-1:0] wdata_next;

   logic ar_hs, aw_hs, w_hs, hdr_hs;
   logic ar_fin, aw_fin, w_fin, hdr_fin;

   // NoC size code: 1..7 means 2^(code-1) bytes, code 0 is treated as one byte
   function automatic logic [2:0] noc_extract_size(input logic [2:0] code);
      return (code == 3'd0) ? 3'd0 : code - 3'd1;
   endfunction

   assign req_type    = bus.req_header[`MSG_TYPE];
   assign noc_addr    = bus.req_header[`MSG_ADDR];
   assign off         = noc_addr[5:0];
   assign size_log    = noc_extract_size(bus.req_header[`MSG_DATA_SIZE]);
   assign nbytes      = 7'd1 << size_log;
   // A 64-byte span shifts the single one out entirely, so the subtraction gives all ones
   assign span        = (64'd1 << nbytes) - 64'd1;
   assign is_rd_type  = (req_type == `MSG_TYPE_LOAD_MEM) || (req_type == `MSG_TYPE_NC_LOAD_REQ);
   assign is_wr_type  = (req_type == `MSG_TYPE_STORE_MEM) || (req_type == `MSG_TYPE_NC_STORE_REQ);
   assign is_nc_store = (req_type == `MSG_TYPE_NC_STORE_REQ);
   assign accept      = (state == IDLE) && bus.req_val;

   // Build the AXI address, strobes and lane-aligned write data for the incoming request
   always_comb begin
      addr_next = '0;
      addr_next[NOC_ADDR_WIDTH-1:0] = noc_addr;
      if (ADDR_MASK_LINE) begin
         addr_next[5:0] = 6'd0;
      end
      strb_next  = '1;
      wdata_next = bus.req_data;
      if (is_nc_store) begin
         strb_next  = span << off;
         wdata_next = bus.req_data << {off, 3'b000};
      end
   end

   assign ar_hs   = arvalid_q && bus.m_axi_arready;
   assign aw_hs   = awvalid_q && bus.m_axi_awready;
   assign w_hs    = wvalid_q  && bus.m_axi_wready;
   assign hdr_hs  = hdr_val_q && bus.hdr_rdy;
   assign ar_fin  = ar_done  || ar_hs;
   assign aw_fin  = aw_done  || aw_hs;
   assign w_fin   = w_done   || w_hs;
   assign hdr_fin = hdr_done || hdr_hs;

   // Capture the request payload on acceptance; contents are don't-care until a valid rises
   always_ff @(posedge clk) begin
      if (accept) begin
         hdr_q   <= bus.req_header;
         addr_q  <= addr_next;
         wdata_q <= wdata_next;
         wstrb_q <= strb_next;
         is_wr_q <= is_wr_type;
      end
   end

   // Issue FSM: each channel drops its valid on its own handshake, leave once all are done
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         arvalid_q <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         hdr_val_q <= 1'b0;
         ar_done   <= 1'b0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         hdr_done  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req_val) begin
                  ar_done  <= 1'b0;
                  aw_done  <= 1'b0;
                  w_done   <= 1'b0;
                  hdr_done <= 1'b0;
                  if (is_rd_type) begin
                     state     <= ISSUE_RD;
                     arvalid_q <= 1'b1;
                     hdr_val_q <= 1'b1;
                  end else if (is_wr_type) begin
                     state     <= ISSUE_WR;
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     hdr_val_q <= 1'b1;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            ISSUE_RD: begin
               if (ar_hs) begin
                  arvalid_q <= 1'b0;
                  ar_done   <= 1'b1;
               end
               if (hdr_hs) begin
                  hdr_val_q <= 1'b0;
                  hdr_done  <= 1'b1;
               end
               if (ar_fin && hdr_fin) begin
                  state    <= IDLE;
                  ar_done  <= 1'b0;
                  hdr_done <= 1'b0;
               end
            end
            ISSUE_WR: begin
               if (aw_hs) begin
                  awvalid_q <= 1'b0;
                  aw_done   <= 1'b1;
               end
               if (w_hs) begin
                  wvalid_q <= 1'b0;
                  w_done   <= 1'b1;
               end
               if (hdr_hs) begin
                  hdr_val_q <= 1'b0;
                  hdr_done  <= 1'b1;
               end
               if (aw_fin && w_fin && hdr_fin) begin
                  state    <= IDLE;
                  aw_done  <= 1'b0;
                  w_done   <= 1'b0;
                  hdr_done <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.req_rdy         = (state == IDLE);

   assign bus.m_axi_araddr    = addr_q;
   assign bus.m_axi_arid      = AXI_ID;
   assign bus.m_axi_arlen     = 8'd0;
   assign bus.m_axi_arsize    = 3'd6;
   assign bus.m_axi_arburst   = 2'b01;
   assign bus.m_axi_arvalid   = arvalid_q;

   assign bus.m_axi_awaddr    = addr_q;
   assign bus.m_axi_awid      = AXI_ID;
   assign bus.m_axi_awlen     = 8'd0;
   assign bus.m_axi_awsize    = 3'd6;
   assign bus.m_axi_awburst   = 2'b01;
   assign bus.m_axi_awvalid   = awvalid_q;

   assign bus.m_axi_wdata     = wdata_q;
   assign bus.m_axi_wstrb     = wstrb_q;
   assign bus.m_axi_wlast     = 1'b1;
   assign bus.m_axi_wvalid    = wvalid_q;

   assign bus.hdr_out         = hdr_q;
   assign bus.hdr_is_wr       = is_wr_q;
   assign bus.hdr_val         = hdr_val_q;

   assign bus.err_unsupported = err_q;

endmodule

// File: tb/tb_noc_axi4_bridge_req_issue.sv
// Testbench for noc_axi4_bridge_req_issue: directed vector table, hand-written
// reset/backpressure sequences and randomized requests against a byte-level model.
`timescale 1ns/1ps
`ifndef NOC_AXI4_BRIDGE_DEFS
`define NOC_AXI4_BRIDGE_DEFS
`define MSG_HEADER_WIDTH 192
`define AXI4_DATA_WIDTH 512
`define AXI4_ADDR_WIDTH 64
`define AXI4_ID_WIDTH 16
`define AXI4_STRB_WIDTH 64
`define MSG_TYPE 29:22
`define MSG_ADDR 111:64
`define MSG_DATA_SIZE 132:130
`define MSG_TYPE_LOAD_MEM 8'd19
`define MSG_TYPE_STORE_MEM 8'd20
`define MSG_TYPE_NC_LOAD_REQ 8'd14
`define MSG_TYPE_NC_STORE_REQ 8'd15
`endif

module tb_noc_axi4_bridge_req_issue;

   logic clk = 1'b0;
   logic rst = 1'b1;

   noc_axi4_bridge_req_issue_if bus();

   noc_axi4_bridge_req_issue dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0]  mtype;
      logic [47:0] addr;
      logic [2:0]  sz;
      logic [31:0] d32;
      int          d_ar, d_aw, d_w, d_hdr;
      int          kind;
      logic [63:0] exp_addr;
      logic [63:0] exp_strb;
      logic [31:0] exp_top;
      int          exp_done;
   } vec_t;

   vec_t vecs[9];

   // Observation results of one request
   int           done_c, n_err, n_stab;
   int           n_ar_v, n_aw_v, n_w_v, n_hdr_v;
   int           n_ar_hs, n_aw_hs, n_w_hs, n_hdr_hs;
   logic [63:0]  cap_ar, cap_aw;
   logic [511:0] cap_wdata;
   logic [63:0]  cap_wstrb;
   logic [191:0] cap_hdr;
   logic         cap_is_wr;

   task automatic check_output(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [191:0] make_hdr(input logic [7:0] t, input logic [47:0] a,
                                             input logic [2:0] sz, input logic [191:0] fill);
      logic [191:0] h;
      h = fill;
      h[29:22]   = t;
      h[111:64]  = a;
      h[132:130] = sz;
      return h;
   endfunction

   // Behavioural model: decode kind, line-aligned address, byte-wise strobes and lanes
   function automatic void model(input logic [191:0] h, input logic [511:0] d, output int kind,
                                 output logic [63:0] ea, output logic [63:0] es, output logic [511:0] ew);
      int t, off, n, code;
      logic [63:0] a;
      t    = int'(h[29:22]);
      a    = {16'h0, h[111:64]};
      code = int'(h[132:130]);
      n    = (code == 0) ? 1 : (1 << (code - 1));
      off  = int'(a % 64);
      if (t == 19 || t == 14) kind = 0;
      else if (t == 20 || t == 15) kind = 1;
      else kind = 2;
      ea = a - (a % 64);
      es = '0;
      ew = '0;
      for (int i = 0; i < 64; i++) begin
         if (t == 20) begin
            es[i] = 1'b1;
            ew[i*8 +: 8] = d[i*8 +: 8];
         end else if (t == 15) begin
            es[i] = (i >= off) && (i < off + n);
            if (i >= off) ew[i*8 +: 8] = d[(i-off)*8 +: 8];
         end
      end
   endfunction

   // Send one request, then play the slave side with per-channel ready delays
   task automatic apply_stimulus(input logic [191:0] h, input logic [511:0] d,
                                 input int d_ar, input int d_aw, input int d_w, input int d_hdr);
      int guard;
      done_c = -1; n_err = 0; n_stab = 0;
      n_ar_v = 0; n_aw_v = 0; n_w_v = 0; n_hdr_v = 0;
      n_ar_hs = 0; n_aw_hs = 0; n_w_hs = 0; n_hdr_hs = 0;
      guard = 0;
      while (!bus.req_rdy && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) check_output("req_rdy_wait", 512'(bus.req_rdy), 512'd1);
      bus.req_header = h;
      bus.req_data   = d;
      bus.req_val    = 1'b1;
      @(negedge clk);
      bus.req_val    = 1'b0;
      for (int c = 1; c <= 60; c++) begin
         bus.m_axi_arready = (c > d_ar);
         bus.m_axi_awready = (c > d_aw);
         bus.m_axi_wready  = (c > d_w);
         bus.hdr_rdy       = (c > d_hdr);
         if (bus.err_unsupported) n_err++;
         if (bus.m_axi_arvalid) begin
            if (n_ar_v == 0) cap_ar = bus.m_axi_araddr;
            else if (cap_ar !== bus.m_axi_araddr) n_stab++;
            n_ar_v++;
            if (bus.m_axi_arready) n_ar_hs++;
         end
         if (bus.m_axi_awvalid) begin
            if (n_aw_v == 0) cap_aw = bus.m_axi_awaddr;
            else if (cap_aw !== bus.m_axi_awaddr) n_stab++;
            n_aw_v++;
            if (bus.m_axi_awready) n_aw_hs++;
         end
         if (bus.m_axi_wvalid) begin
            if (n_w_v == 0) begin
               cap_wdata = bus.m_axi_wdata;
               cap_wstrb = bus.m_axi_wstrb;
            end else if (cap_wdata !== bus.m_axi_wdata || cap_wstrb !== bus.m_axi_wstrb) n_stab++;
            n_w_v++;
            if (bus.m_axi_wready) n_w_hs++;
         end
         if (bus.hdr_val) begin
            if (n_hdr_v == 0) begin
               cap_hdr   = bus.hdr_out;
               cap_is_wr = bus.hdr_is_wr;
            end else if (cap_hdr !== bus.hdr_out) n_stab++;
            n_hdr_v++;
            if (bus.hdr_rdy) n_hdr_hs++;
         end
         if (bus.req_rdy) begin
            done_c = c;
            break;
         end
         @(negedge clk);
      end
      bus.m_axi_arready = 1'b0;
      bus.m_axi_awready = 1'b0;
      bus.m_axi_wready  = 1'b0;
      bus.hdr_rdy       = 1'b0;
      @(negedge clk);
      if (bus.err_unsupported) n_err++;
   endtask

   // Checks shared by every request: handshake counts, valid lifetimes, header handoff
   task automatic check_common(input int kind, input int d_ar, input int d_aw, input int d_w,
                               input int d_hdr, input int exp_done, input logic [191:0] h);
      check_output("done_cycle", 512'(done_c), 512'(exp_done));
      check_output("err_pulses", 512'(n_err), 512'(kind == 2 ? 1 : 0));
      check_output("stability", 512'(n_stab), 512'd0);
      if (kind == 0) begin
         check_output("ar_hs", 512'(n_ar_hs), 512'd1);
         check_output("hdr_hs", 512'(n_hdr_hs), 512'd1);
         check_output("ar_valid_cycles", 512'(n_ar_v), 512'(d_ar + 1));
         check_output("hdr_valid_cycles", 512'(n_hdr_v), 512'(d_hdr + 1));
         check_output("no_write_valids", 512'(n_aw_v + n_w_v), 512'd0);
         check_output("hdr_is_wr", 512'(cap_is_wr), 512'd0);
         check_output("hdr_out", 512'(cap_hdr), 512'(h));
      end else if (kind == 1) begin
         check_output("aw_hs", 512'(n_aw_hs), 512'd1);
         check_output("w_hs", 512'(n_w_hs), 512'd1);
         check_output("hdr_hs", 512'(n_hdr_hs), 512'd1);
         check_output("aw_valid_cycles", 512'(n_aw_v), 512'(d_aw + 1));
         check_output("w_valid_cycles", 512'(n_w_v), 512'(d_w + 1));
         check_output("hdr_valid_cycles", 512'(n_hdr_v), 512'(d_hdr + 1));
         check_output("no_ar_valid", 512'(n_ar_v), 512'd0);
         check_output("hdr_is_wr", 512'(cap_is_wr), 512'd1);
         check_output("hdr_out", 512'(cap_hdr), 512'(h));
      end else begin
         check_output("no_valids", 512'(n_ar_v + n_aw_v + n_w_v + n_hdr_v), 512'd0);
      end
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL global_timeout: got running expected finished");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      logic [191:0] h;
      logic [511:0] d;
      logic [63:0]  ea, es;
      logic [511:0] ew;
      int           kind, dar, daw, dw, dh, ed, r;
      logic [7:0]   t;

      bus.req_header    = '0;
      bus.req_data      = '0;
      bus.req_val       = 1'b0;
      bus.m_axi_arready = 1'b0;
      bus.m_axi_awready = 1'b0;
      bus.m_axi_wready  = 1'b0;
      bus.hdr_rdy       = 1'b0;

      //                 type   addr              sz    d32           ar aw w  hd kind addr                     strb                     top           done
      vecs[0] = '{8'h13, 48'h0000_8000_1234, 3'd7, 32'h0,        0, 0, 0, 0, 0, 64'h0000_0000_8000_1200, 64'h0,                   32'h0,        2};
      vecs[1] = '{8'h14, 48'h0000_0000_0040, 3'd7, 32'hDEADBEEF, 0, 5, 0, 0, 1, 64'h0000_0000_0000_0040, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0,        7};
      vecs[2] = '{8'h0F, 48'h0000_1000_003C, 3'd3, 32'hDEADBEEF, 0, 0, 0, 0, 1, 64'h0000_0000_1000_0000, 64'hF000_0000_0000_0000, 32'hDEADBEEF, 2};
      vecs[3] = '{8'h0F, 48'h0000_0000_003E, 3'd4, 32'hCAFEF00D, 0, 0, 0, 0, 1, 64'h0,                   64'hC000_0000_0000_0000, 32'hF00D0000, 2};
      vecs[4] = '{8'h0E, 48'h0000_0000_1005, 3'd2, 32'h0,        2, 0, 0, 0, 0, 64'h0000_0000_0000_1000, 64'h0,                   32'h0,        4};
      vecs[5] = '{8'h00, 48'h0000_0000_2000, 3'd1, 32'h0,        0, 0, 0, 0, 2, 64'h0,                   64'h0,                   32'h0,        1};
      vecs[6] = '{8'h0F, 48'h0000_0000_0000, 3'd7, 32'h11223344, 0, 0, 0, 3, 1, 64'h0,                   64'hFFFF_FFFF_FFFF_FFFF, 32'h0,        5};
      vecs[7] = '{8'h14, 48'h0000_0000_1255, 3'd7, 32'h55AA55AA, 0, 0, 2, 1, 1, 64'h0000_0000_0000_1240, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0,        4};
      vecs[8] = '{8'h13, 48'hFFFF_FFFF_FFFF, 3'd7, 32'h0,        0, 0, 0, 3, 0, 64'h0000_FFFF_FFFF_FFC0, 64'h0,                   32'h0,        5};

      // Reset and the first cycle after it
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_output("reset_req_rdy", 512'(bus.req_rdy), 512'd1);
      check_output("reset_valids", 512'({bus.m_axi_arvalid, bus.m_axi_awvalid, bus.m_axi_wvalid, bus.hdr_val}), 512'd0);
      check_output("reset_err", 512'(bus.err_unsupported), 512'd0);
      check_output("static_fields",
                   512'({bus.m_axi_arlen, bus.m_axi_arsize, bus.m_axi_arburst, bus.m_axi_awlen,
                         bus.m_axi_awsize, bus.m_axi_awburst, bus.m_axi_wlast}),
                   512'({8'd0, 3'd6, 2'b01, 8'd0, 3'd6, 2'b01, 1'b1}));
      check_output("axi_ids", 512'({bus.m_axi_arid, bus.m_axi_awid}), 512'd0);

      // Directed vector table
      for (int i = 0; i < 9; i++) begin
         h = make_hdr(vecs[i].mtype, vecs[i].addr, vecs[i].sz, 192'h0);
         d = {480'h0, vecs[i].d32};
         apply_stimulus(h, d, vecs[i].d_ar, vecs[i].d_aw, vecs[i].d_w, vecs[i].d_hdr);
         check_common(vecs[i].kind, vecs[i].d_ar, vecs[i].d_aw, vecs[i].d_w, vecs[i].d_hdr,
                      vecs[i].exp_done, h);
         if (vecs[i].kind == 0) check_output("vec_araddr", 512'(cap_ar), 512'(vecs[i].exp_addr));
         if (vecs[i].kind == 1) begin
            check_output("vec_awaddr", 512'(cap_aw), 512'(vecs[i].exp_addr));
            check_output("vec_wstrb", 512'(cap_wstrb), 512'(vecs[i].exp_strb));
            check_output("vec_wdata_top", 512'(cap_wdata[511:480]), 512'(vecs[i].exp_top));
         end
      end

      // Reset in the middle of a write with AW still pending
      h = make_hdr(`MSG_TYPE_STORE_MEM, 48'h0000_0000_3000, 3'd7, 192'h0);
      bus.req_header = h;
      bus.req_data   = '1;
      bus.req_val    = 1'b1;
      @(negedge clk);
      bus.req_val    = 1'b0;
      check_output("pre_rst_awvalid", 512'(bus.m_axi_awvalid), 512'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_output("mid_rst_valids", 512'({bus.m_axi_arvalid, bus.m_axi_awvalid, bus.m_axi_wvalid, bus.hdr_val}), 512'd0);
      check_output("mid_rst_req_rdy", 512'(bus.req_rdy), 512'd1);
      rst = 1'b0;
      @(negedge clk);

      // Randomized requests against the reference model
      for (int i = 0; i < 40; i++) begin
         r = int'($urandom_range(0, 9));
         case (r)
            0, 1, 9: t = `MSG_TYPE_LOAD_MEM;
            2, 3:    t = `MSG_TYPE_NC_LOAD_REQ;
            4, 5:    t = `MSG_TYPE_STORE_MEM;
            6, 7:    t = `MSG_TYPE_NC_STORE_REQ;
            default: t = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'h55;
         endcase
         h = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         h = make_hdr(t, {$urandom, $urandom}, 3'($urandom_range(0, 7)), h);
         for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
         dar = int'($urandom_range(0, 3));
         daw = int'($urandom_range(0, 3));
         dw  = int'($urandom_range(0, 3));
         dh  = int'($urandom_range(0, 3));
         model(h, d, kind, ea, es, ew);
         if (kind == 0) ed = ((dar > dh) ? dar : dh) + 2;
         else if (kind == 1) ed = ((daw > dw) ? ((daw > dh) ? daw : dh) : ((dw > dh) ? dw : dh)) + 2;
         else ed = 1;
         apply_stimulus(h, d, dar, daw, dw, dh);
         check_common(kind, dar, daw, dw, dh, ed, h);
         if (kind == 0) check_output("rnd_araddr", 512'(cap_ar), 512'(ea));
         if (kind == 1) begin
            check_output("rnd_awaddr", 512'(cap_aw), 512'(ea));
            check_output("rnd_wstrb", 512'(cap_wstrb), 512'(es));
            check_output("rnd_wdata", cap_wdata, ew);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
